// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide,
// one result bit per clock, with HI/LO registers and MTHI/MTLO write ports.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

  localparam logic [WIDTH-1:0]   ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES     = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] ONE2     = (2*WIDTH)'(1);

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               sa_s, sb_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic               div_ge_s;
  logic [2*WIDTH-1:0] step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  // Operand conditioning, one iteration step and the final sign fix-up.
  always_comb begin
    sa_s        = op[0] & a[WIDTH-1];
    sb_s        = op[0] & b[WIDTH-1];
    mag_a_s     = neg_if(a, sa_s);
    mag_b_s     = neg_if(b, sb_s);
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : ZERO)};
    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_q};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
    // Remainder always fits WIDTH bits since it stays below the divisor.
    if (is_div_q) begin
      step_s = {(div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0]),
                acc_q[WIDTH-2:0], div_ge_s};
    end else begin
      step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
    if (sign_a_q ^ sign_b_q) begin
      prod_s = ~acc_q + ONE2;
    end else begin
      prod_s = acc_q;
    end
    quo_s = neg_if(acc_q[WIDTH-1:0], sign_a_q ^ sign_b_q);
    rem_s = neg_if(acc_q[2*WIDTH-1:WIDTH], sign_a_q);
  end

  // Next-state and register-update logic for IDLE/CALC/FIX.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_we) begin
          hi_d = wdata;
        end else begin
          hi_d = hi_q;
        end
        if (lo_we) begin
          lo_d = wdata;
        end else begin
          lo_d = lo_q;
        end
        if (start) begin
          busy_d   = 1'b1;
          cnt_d    = {CNT_W{1'b0}};
          is_div_d = op[1];
          sign_a_d = sa_s;
          sign_b_d = sb_s;
          if (op[1] && (b == ZERO)) begin
            // Divide by zero skips the iteration; FIX publishes {a, all-ones}.
            state_d = S_FIX;
            dz_d    = 1'b1;
            opnd_d  = ZERO;
            acc_d   = {a, ONES};
          end else if (op[1]) begin
            state_d = S_CALC;
            dz_d    = 1'b0;
            opnd_d  = mag_b_s;
            acc_d   = {ZERO, mag_a_s};
          end else begin
            state_d = S_CALC;
            dz_d    = 1'b0;
            opnd_d  = mag_a_s;
            acc_d   = {ZERO, mag_b_s};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d = step_s;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (dz_q) begin
          hi_d  = acc_q[2*WIDTH-1:WIDTH];
          lo_d  = acc_q[WIDTH-1:0];
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          hi_d  = rem_s;
          lo_d  = quo_s;
        end else begin
          hi_d  = prod_s[2*WIDTH-1:WIDTH];
          lo_d  = prod_s[WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and result registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= ZERO;
      acc_q    <= {2*WIDTH{1'b0}};
      hi_q     <= ZERO;
      lo_q     <= ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
